// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: round-robin between ALU (A) and load (B)
// writebacks, one registered RF write per cycle, plus a pending-write
// scoreboard and a sticky error for writes to registers not marked busy.
module regfile_wb_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        a_valid,
  input  logic [2:0]  a_dr,
  input  logic [15:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [2:0]  b_dr,
  input  logic [15:0] b_data,
  output logic        b_ready,
  input  logic        issue_valid,
  input  logic [2:0]  issue_dr,
  output logic [7:0]  busy,
  output logic        rf_ld_reg,
  output logic [2:0]  rf_dr,
  output logic [15:0] rf_data,
  output logic        wb_err
);

  localparam int unsigned DR_W   = 3;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned NREG   = 8;

  // Encoding of the most recently granted requester.
  localparam logic [0:0] LG_A = 1'b0;
  localparam logic [0:0] LG_B = 1'b1;

  logic [0:0]        last_grant_q, last_grant_d;
  logic              rf_ld_reg_q, rf_ld_reg_d;
  logic [DR_W-1:0]   rf_dr_q, rf_dr_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              wb_err_q, wb_err_d;

  logic grant_a, grant_b;

  // Round-robin grant; the requester not served last wins a contention.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset && !hold) begin
      if (a_valid && b_valid) begin
        grant_a = (last_grant_q == LG_B);
        grant_b = (last_grant_q == LG_A);
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Next-state: capture the accepted write, update scoreboard and error.
  always_comb begin
    last_grant_d = last_grant_q;
    rf_ld_reg_d  = 1'b0;
    rf_dr_d      = rf_dr_q;
    rf_data_d    = rf_data_q;
    busy_d       = busy_q;
    wb_err_d     = wb_err_q;

    if (grant_a) begin
      last_grant_d = LG_A;
      rf_ld_reg_d  = 1'b1;
      rf_dr_d      = a_dr;
      rf_data_d    = a_data;
    end else if (grant_b) begin
      last_grant_d = LG_B;
      rf_ld_reg_d  = 1'b1;
      rf_dr_d      = b_dr;
      rf_data_d    = b_data;
    end

    // Clear first so that a same-cycle issue to the same register wins.
    if (rf_ld_reg_q) begin
      busy_d[rf_dr_q] = 1'b0;
      if (!busy_q[rf_dr_q]) wb_err_d = 1'b1;
    end
    if (issue_valid) busy_d[issue_dr] = 1'b1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= LG_B;
      rf_ld_reg_q  <= 1'b0;
      rf_dr_q      <= DR_W'(0);
      rf_data_q    <= DATA_W'(0);
      busy_q       <= NREG'(0);
      wb_err_q     <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_ld_reg_q  <= rf_ld_reg_d;
      rf_dr_q      <= rf_dr_d;
      rf_data_q    <= rf_data_d;
      busy_q       <= busy_d;
      wb_err_q     <= wb_err_d;
    end
  end

  assign rf_ld_reg = rf_ld_reg_q;
  assign rf_dr     = rf_dr_q;
  assign rf_data   = rf_data_q;
  assign busy      = busy_q;
  assign wb_err    = wb_err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset, hold;
  logic        a_valid, b_valid, issue_valid;
  logic [2:0]  a_dr, b_dr, issue_dr;
  logic [15:0] a_data, b_data;
  logic        a_ready, b_ready, rf_ld_reg, wb_err;
  logic [7:0]  busy;
  logic [2:0]  rf_dr;
  logic [15:0] rf_data;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter dut (
    .clk(clk), .reset(reset), .hold(hold),
    .a_valid(a_valid), .a_dr(a_dr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_dr(b_dr), .b_data(b_data), .b_ready(b_ready),
    .issue_valid(issue_valid), .issue_dr(issue_dr), .busy(busy),
    .rf_ld_reg(rf_ld_reg), .rf_dr(rf_dr), .rf_data(rf_data), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0;
    a_valid = 1'b0; a_dr = 3'd0; a_data = 16'h0;
    b_valid = 1'b0; b_dr = 3'd0; b_data = 16'h0;
    issue_valid = 1'b0; issue_dr = 3'd0;
    tick(); tick();

    // Reset state; readies forced low during reset even with a valid.
    a_valid = 1'b1; #1;
    chk("rst_a_ready", 16'(a_ready), 16'h0);
    chk("rst_rf_ld",   16'(rf_ld_reg), 16'h0);
    chk("rst_rf_dr",   16'(rf_dr), 16'h0);
    chk("rst_rf_data", rf_data, 16'h0000);
    chk("rst_busy",    16'(busy), 16'h00);
    chk("rst_wb_err",  16'(wb_err), 16'h0);
    a_valid = 1'b0;
    reset = 1'b0;

    // Single A write to an issued register.
    issue_valid = 1'b1; issue_dr = 3'd3;
    tick();
    issue_valid = 1'b0;
    chk("t1_busy_set", 16'(busy), 16'h08);
    a_valid = 1'b1; a_dr = 3'd3; a_data = 16'h1234; #1;
    chk("t1_a_ready", 16'(a_ready), 16'h1);
    chk("t1_b_ready", 16'(b_ready), 16'h0);
    tick();
    a_valid = 1'b0;
    chk("t1_rf_ld",   16'(rf_ld_reg), 16'h1);
    chk("t1_rf_dr",   16'(rf_dr), 16'h3);
    chk("t1_rf_data", rf_data, 16'h1234);
    chk("t1_busy_n1", 16'(busy), 16'h08);
    tick();
    chk("t1_rf_ld_off", 16'(rf_ld_reg), 16'h0);
    chk("t1_rf_dr_hold", 16'(rf_dr), 16'h3);
    chk("t1_rf_data_hold", rf_data, 16'h1234);
    chk("t1_busy_clr", 16'(busy), 16'h00);
    chk("t1_wb_err",  16'(wb_err), 16'h0);

    // Round-robin with both valid: A, B, A.
    do_reset();
    issue_valid = 1'b1; issue_dr = 3'd1; tick();
    issue_dr = 3'd2; tick();
    issue_valid = 1'b0;
    chk("t2_busy", 16'(busy), 16'h06);
    a_valid = 1'b1; a_dr = 3'd1; a_data = 16'hAAAA;
    b_valid = 1'b1; b_dr = 3'd2; b_data = 16'hBBBB; #1;
    chk("t2_g1_a", 16'(a_ready), 16'h1);
    chk("t2_g1_b", 16'(b_ready), 16'h0);
    tick();
    chk("t2_w1_ld", 16'(rf_ld_reg), 16'h1);
    chk("t2_w1_dr", 16'(rf_dr), 16'h1);
    chk("t2_w1_data", rf_data, 16'hAAAA);
    chk("t2_g2_a", 16'(a_ready), 16'h0);
    chk("t2_g2_b", 16'(b_ready), 16'h1);
    tick();
    chk("t2_w2_ld", 16'(rf_ld_reg), 16'h1);
    chk("t2_w2_dr", 16'(rf_dr), 16'h2);
    chk("t2_w2_data", rf_data, 16'hBBBB);
    chk("t2_busy_w1", 16'(busy), 16'h04);
    chk("t2_g3_a", 16'(a_ready), 16'h1);
    chk("t2_g3_b", 16'(b_ready), 16'h0);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("t2_w3_ld", 16'(rf_ld_reg), 16'h1);
    chk("t2_w3_dr", 16'(rf_dr), 16'h1);
    chk("t2_busy_w2", 16'(busy), 16'h00);
    chk("t2_err_pre", 16'(wb_err), 16'h0);
    tick();
    chk("t2_ld_off", 16'(rf_ld_reg), 16'h0);
    chk("t2_err_r1_again", 16'(wb_err), 16'h1);

    // Hold blocks both requesters; A wins once hold drops.
    do_reset();
    hold = 1'b1;
    a_valid = 1'b1; a_dr = 3'd7; a_data = 16'h7777;
    b_valid = 1'b1; b_dr = 3'd0; b_data = 16'h0F0F;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3_hold_a", 16'(a_ready), 16'h0);
      chk("t3_hold_b", 16'(b_ready), 16'h0);
      tick();
      chk("t3_hold_ld", 16'(rf_ld_reg), 16'h0);
    end
    hold = 1'b0; #1;
    chk("t3_rel_a", 16'(a_ready), 16'h1);
    chk("t3_rel_b", 16'(b_ready), 16'h0);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("t3_rel_ld", 16'(rf_ld_reg), 16'h1);
    chk("t3_rel_dr", 16'(rf_dr), 16'h7);
    chk("t3_rel_data", rf_data, 16'h7777);

    // Same-cycle set and clear of r5: set wins; hold leaves registered write alone.
    do_reset();
    issue_valid = 1'b1; issue_dr = 3'd5; tick();
    issue_valid = 1'b0;
    a_valid = 1'b1; a_dr = 3'd5; a_data = 16'h5555; tick();
    a_valid = 1'b0;
    hold = 1'b1; issue_valid = 1'b1; issue_dr = 3'd5; #1;
    chk("t4_ld_under_hold", 16'(rf_ld_reg), 16'h1);
    chk("t4_dr", 16'(rf_dr), 16'h5);
    tick();
    issue_valid = 1'b0; hold = 1'b0;
    chk("t4_busy_kept", 16'(busy), 16'h20);
    chk("t4_wb_err", 16'(wb_err), 16'h0);

    // B write to non-busy r6 raises sticky wb_err.
    b_valid = 1'b1; b_dr = 3'd6; b_data = 16'h6666; #1;
    chk("t5_b_ready", 16'(b_ready), 16'h1);
    tick();
    b_valid = 1'b0;
    chk("t5_ld", 16'(rf_ld_reg), 16'h1);
    chk("t5_dr", 16'(rf_dr), 16'h6);
    chk("t5_data", rf_data, 16'h6666);
    chk("t5_err_pre", 16'(wb_err), 16'h0);
    tick();
    chk("t5_err_set", 16'(wb_err), 16'h1);
    tick(); tick();
    chk("t5_err_sticky", 16'(wb_err), 16'h1);
    do_reset();
    chk("t5_err_rst", 16'(wb_err), 16'h0);

    // Reset during the acceptance cycle of a_dr=4 discards it.
    issue_valid = 1'b1; issue_dr = 3'd4; tick();
    issue_valid = 1'b0;
    chk("t6_busy", 16'(busy), 16'h10);
    a_valid = 1'b1; a_dr = 3'd4; a_data = 16'h4444; reset = 1'b1; #1;
    chk("t6_a_ready", 16'(a_ready), 16'h0);
    tick();
    reset = 1'b0; a_valid = 1'b0;
    chk("t6_ld", 16'(rf_ld_reg), 16'h0);
    chk("t6_busy_rst", 16'(busy), 16'h00);
    chk("t6_data", rf_data, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 SHALL provide ports (name  direction  width  meaning):
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous active-high reset
- hold  in  1  freeze grants; no requester accepted while high
- a_valid  in  1  requester A (ALU writeback) has a write
- a_dr  in  3  requester A destination register
- a_data  in  16  requester A write data
- a_ready  out  1  A accepted this cycle
- b_valid  in  1  requester B (memory-load writeback) has a write
- b_dr  in  3  requester B destination register
- b_data  in  16  requester B write data
- b_ready  out  1  B accepted this cycle
- issue_valid  in  1  decoder marks a register as pending write
- issue_dr  in  3  register being marked pending
- busy  out  8  per-register pending-write scoreboard
- rf_ld_reg  out  1  write enable to register file port
- rf_dr  out  3  register file destination select
- rf_data  out  16  register file write data
- wb_err  out  1  sticky: write issued to a non-busy register

Function
REQ-003 SHALL accept at most one requester per cycle; acceptance = x_valid & x_ready at posedge.
REQ-004 SHALL drive a_ready/b_ready combinationally; both SHALL be 0 when hold=1 or reset=1.
REQ-005 SHALL assert x_ready only when x_valid=1; ready SHALL never be high for both in one cycle.
REQ-006 Only one valid: that requester SHALL be granted.
REQ-007 Both valid: SHALL grant the requester not granted most recently (round-robin, 1-bit last_grant state).
REQ-008 last_grant SHALL update only on an acceptance; reset value SHALL be B, so A wins the first contention.
REQ-009 Requesters SHALL hold valid/dr/data stable until accepted; block SHALL sample dr/data only on the acceptance cycle.
REQ-010 Acceptance in cycle N SHALL produce rf_ld_reg=1, rf_dr, rf_data registered in cycle N+1 (latency 1); otherwise rf_ld_reg=0 in N+1.
REQ-011 rf_dr/rf_data SHALL hold their last value when rf_ld_reg=0.
REQ-012 Back-to-back acceptances SHALL yield rf_ld_reg high on consecutive cycles (throughput 1 write/cycle).
REQ-013 busy[r] SHALL set at the posedge where issue_valid=1 and issue_dr=r.
REQ-014 busy[r] SHALL clear at the posedge ending a cycle with rf_ld_reg=1 and rf_dr=r.
REQ-015 Set and clear of the same register in one cycle: set SHALL win (busy stays 1).
REQ-016 busy SHALL be a registered output; it reflects issue/clear one cycle later.
REQ-017 wb_err SHALL set at the posedge where rf_ld_reg=1 and busy[rf_dr]=0, then remain 1 until reset.
REQ-018 hold SHALL NOT suppress a write already registered on rf_* outputs; it blocks only new acceptances.
REQ-019 Arbitration SHALL be independent of dr values; two writes to the same register SHALL issue in acceptance order.

Reset
REQ-020 With reset=1 at posedge: rf_ld_reg=0, rf_dr=0, rf_data=16'h0000, busy=8'h00, wb_err=0, last_grant=B.
REQ-021 Reset mid-transfer SHALL discard any acceptance in that cycle (readies forced 0) and cancel the pending rf write.
REQ-022 Reset SHALL NOT clear register-file contents; the block only gates rf_ld_reg.

Verification
REQ-023 Issue dr=3; then a_valid, a_dr=3, a_data=16'h1234 only -> a_ready=1 cycle N; cycle N+1 rf_ld_reg=1, rf_dr=3, rf_data=16'h1234; busy[3] 1 then 0 at N+2; wb_err=0.
REQ-024 After reset, issue r1,r2; a_valid and b_valid held 3 cycles (A dr=1, B dr=2) -> grants A,B,A; rf_ld_reg high 3 consecutive cycles.
REQ-025 hold=1 with both valid for 4 cycles -> a_ready=b_ready=0, rf_ld_reg=0; hold drops -> A granted next cycle.
REQ-026 rf_ld_reg=1, rf_dr=5 in same cycle as issue_valid, issue_dr=5 with busy[5]=1 -> busy[5] remains 1.
REQ-027 b_valid, b_dr=6 with busy[6]=0 -> write issued, wb_err=1 and stays 1 until reset.
REQ-028 Reset asserted in acceptance cycle of a_dr=4 -> a_ready=0, next cycle rf_ld_reg=0, busy=8'h00.
